// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants and state encoding for the sequential BCD converter
package bcd_pkg;

    localparam int BIN_W_DEF      = 24;
    localparam int DIGITS_DEF     = 6;
    // 8 digits hold any 24-bit magnitude (2^24 = 16777216)
    localparam int SCRATCH_DIGITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Saturation pattern shown on the display when the magnitude does not fit
    localparam logic [4*DIGITS_DEF-1:0] BCD_SAT = 24'h999999;

endpackage

// File: rtl/bcd_seq_conv_if.sv
// rtl/bcd_seq_conv_if.sv - request/result bundle between the value register and the converter
interface bcd_seq_conv_if
    import bcd_pkg::*;
#(
    parameter int BIN_W  = BIN_W_DEF,
    parameter int DIGITS = DIGITS_DEF
);

    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  neg;
    logic                  ovf;

    modport master (
        output start, bin,
        input  busy, done, bcd, neg, ovf
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, neg, ovf
    );

endinterface

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble digit correction, adds 3 to digits of 5 or more
module bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);

    // Per-digit correction so the following left shift carries correctly into the next digit
    always_comb begin
        q = (d >= 4'd5) ? (d + 4'd3) : d;
    end

endmodule

// File: rtl/bcd_seq_conv.sv
// rtl/bcd_seq_conv.sv - signed binary to BCD converter, one double-dabble step per clock
module bcd_seq_conv
    import bcd_pkg::*;
#(
    parameter int BIN_W  = BIN_W_DEF,
    parameter int DIGITS = DIGITS_DEF,
    parameter int AUTO   = 1
) (
    input  logic           clk,
    input  logic           rst,
    bcd_seq_conv_if.slave  bus
);

    localparam int SCRATCH_W = 4 * SCRATCH_DIGITS;
    localparam int OUT_W     = 4 * DIGITS;
    localparam int CNT_W     = $clog2(BIN_W + 1);
    localparam logic [OUT_W-1:0] SAT = {DIGITS{4'h9}};

    state_t                 state;
    state_t                 state_nxt;
    logic [BIN_W-1:0]       last;
    logic [BIN_W-1:0]       mag;
    logic [SCRATCH_W-1:0]   scratch;
    logic [SCRATCH_W-1:0]   scratch_adj;
    logic [SCRATCH_W+BIN_W-1:0] shifted;
    logic [CNT_W-1:0]       cnt;
    logic                   neg_cap;
    logic [OUT_W-1:0]       bcd_r;
    logic                   neg_r;
    logic                   ovf_r;
    logic                   done_r;
    logic                   trigger;
    logic                   last_iter;
    logic                   over;

    assign trigger   = bus.start || ((AUTO != 0) && (bus.bin != last));
    assign last_iter = (cnt == CNT_W'(BIN_W - 1));
    assign over      = |scratch[SCRATCH_W-1:OUT_W];

    genvar g;
    generate
        for (g = 0; g < SCRATCH_DIGITS; g++) begin : g_add3
            bcd_add3 u_add3 (
                .d (scratch[4*g +: 4]),
                .q (scratch_adj[4*g +: 4])
            );
        end
    endgenerate

    // Corrected digits and remaining magnitude bits move left as one long register
    always_comb begin
        shifted = {scratch_adj, mag} << 1;
    end

    // State register; reset aborts any conversion in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: accept a request in IDLE, run BIN_W steps, then publish for one cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (trigger)   state_nxt = SHIFT;
            SHIFT:   if (last_iter) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture on accept, iterate in SHIFT, update visible outputs only in DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last    <= '0;
            mag     <= '0;
            scratch <= '0;
            cnt     <= '0;
            neg_cap <= 1'b0;
            bcd_r   <= '0;
            neg_r   <= 1'b0;
            ovf_r   <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= (state == DONE);
            case (state)
                IDLE: begin
                    if (trigger) begin
                        last    <= bus.bin;
                        neg_cap <= bus.bin[BIN_W-1];
                        mag     <= bus.bin[BIN_W-1] ? (BIN_W'(0) - bus.bin) : bus.bin;
                        scratch <= '0;
                        cnt     <= '0;
                    end
                end
                SHIFT: begin
                    {scratch, mag} <= shifted;
                    cnt            <= cnt + 1'b1;
                end
                DONE: begin
                    bcd_r <= over ? SAT : scratch[OUT_W-1:0];
                    neg_r <= neg_cap;
                    ovf_r <= over;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_r;
    assign bus.bcd  = bcd_r;
    assign bus.neg  = neg_r;
    assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_bcd_seq_conv.sv
// tb/tb_bcd_seq_conv.sv - scoreboard bench for bcd_seq_conv in manual and auto-trigger modes
module tb_bcd_seq_conv;
    import bcd_pkg::*;

    typedef struct packed {
        logic [23:0] bcd;
        logic        neg;
        logic        ovf;
    } exp_t;

    logic clk  = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;

    always #5 clk = ~clk;

    bcd_seq_conv_if bus0 ();
    bcd_seq_conv_if bus1 ();

    bcd_seq_conv #(.AUTO(0)) dut0 (.clk(clk), .rst(rst0), .bus(bus0));
    bcd_seq_conv #(.AUTO(1)) dut1 (.clk(clk), .rst(rst1), .bus(bus1));

    exp_t q0[$];
    exp_t q1[$];
    int   total = 0;
    int   bad   = 0;
    int   done0_cnt = 0;
    int   done1_cnt = 0;

    function automatic exp_t mk(input logic [23:0] b, input logic n, input logic o);
        exp_t e;
        e.bcd = b;
        e.neg = n;
        e.ovf = o;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    always @(negedge clk) begin : mon0
        exp_t e;
        if (rst0 === 1'b1 && bus0.done === 1'b1) begin
            done0_cnt++;
            if (q0.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dut0 unexpected done: got bcd %0h want no done", bus0.bcd);
            end else begin
                e = q0.pop_front();
                check("dut0 bcd", 32'(bus0.bcd), 32'(e.bcd));
                check("dut0 neg", 32'(bus0.neg), 32'(e.neg));
                check("dut0 ovf", 32'(bus0.ovf), 32'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (rst1 === 1'b1 && bus1.done === 1'b1) begin
            done1_cnt++;
            if (q1.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dut1 unexpected done: got bcd %0h want no done", bus1.bcd);
            end else begin
                e = q1.pop_front();
                check("dut1 bcd", 32'(bus1.bcd), 32'(e.bcd));
                check("dut1 neg", 32'(bus1.neg), 32'(e.neg));
                check("dut1 ovf", 32'(bus1.ovf), 32'(e.ovf));
            end
        end
    end

    // Issue one start on dut0 and check busy width and done latency; optionally
    // fire a second start with poke_v at cycle poke_at while busy.
    task automatic run0(input logic [23:0] v, input exp_t e, input int poke_at, input logic [23:0] poke_v);
        int lat;
        int busy_n;
        lat    = 0;
        busy_n = 0;
        q0.push_back(e);
        bus0.bin   = v;
        bus0.start = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            bus0.start = 1'b0;
            if (i == poke_at) begin
                bus0.bin   = poke_v;
                bus0.start = 1'b1;
            end
            if (bus0.busy === 1'b1) busy_n++;
            if (bus0.done === 1'b1) begin
                lat = i;
                break;
            end
        end
        check("dut0 done latency", 32'(lat), 32'd26);
        check("dut0 busy cycles", 32'(busy_n), 32'd25);
    endtask

    task automatic drain1(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (q1.size() == 0) break;
        end
        check("dut1 queue drained", 32'(q1.size()), 32'd0);
    endtask

    initial begin
        int snap;
        bus0.start = 1'b0;
        bus0.bin   = '0;
        bus1.start = 1'b0;
        bus1.bin   = '0;

        #2;
        rst0 = 1'b0;
        rst1 = 1'b0;
        #1;
        check("reset busy", 32'(bus0.busy), 32'd0);
        check("reset done", 32'(bus0.done), 32'd0);
        check("reset bcd", 32'(bus0.bcd), 32'd0);
        check("reset neg/ovf", 32'({bus0.neg, bus0.ovf}), 32'd0);
        check("reset dut1 busy", 32'(bus1.busy), 32'd0);
        repeat (3) @(negedge clk);
        rst0 = 1'b1;
        rst1 = 1'b1;
        @(negedge clk);

        run0(24'd123456,  mk(24'h123456, 1'b0, 1'b0), 0, 24'd0);
        run0(24'hFFFFFF,  mk(24'h000001, 1'b1, 1'b0), 0, 24'd0);
        run0(24'd0,       mk(24'h000000, 1'b0, 1'b0), 0, 24'd0);
        run0(24'd1000000, mk(24'h999999, 1'b0, 1'b1), 0, 24'd0);
        run0(24'h800000,  mk(24'h999999, 1'b1, 1'b1), 0, 24'd0);
        run0(24'd999999,  mk(24'h999999, 1'b0, 1'b0), 0, 24'd0);

        snap = done0_cnt;
        run0(24'd42, mk(24'h000042, 1'b0, 1'b0), 5, 24'd77);
        run0(24'd77, mk(24'h000077, 1'b0, 1'b0), 0, 24'd0);
        check("dut0 done pulses for 42/77", 32'(done0_cnt - snap), 32'd2);

        bus0.bin   = 24'd500;
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        repeat (9) @(negedge clk);
        rst0 = 1'b0;
        #1;
        check("async reset busy", 32'(bus0.busy), 32'd0);
        check("async reset done", 32'(bus0.done), 32'd0);
        check("async reset bcd", 32'(bus0.bcd), 32'd0);
        check("async reset neg/ovf", 32'({bus0.neg, bus0.ovf}), 32'd0);
        @(negedge clk);
        rst0 = 1'b1;
        snap = done0_cnt;
        repeat (40) @(negedge clk);
        check("no done after reset", 32'(done0_cnt - snap), 32'd0);

        snap = done1_cnt;
        repeat (10) @(negedge clk);
        check("auto idle with bin=0", 32'(done1_cnt - snap), 32'd0);

        q1.push_back(mk(24'h000305, 1'b0, 1'b0));
        bus1.bin = 24'd305;
        drain1(60);
        snap = done1_cnt;
        repeat (40) @(negedge clk);
        check("auto steady bin no done", 32'(done1_cnt - snap), 32'd0);

        q1.push_back(mk(24'h000007, 1'b0, 1'b0));
        bus1.bin = 24'd7;
        repeat (5) @(negedge clk);
        check("auto busy during conversion", 32'(bus1.busy), 32'd1);
        q1.push_back(mk(24'h000020, 1'b1, 1'b0));
        bus1.bin = 24'hFFFFEC;
        drain1(100);

        snap = done1_cnt;
        q1.push_back(mk(24'h000099, 1'b0, 1'b0));
        bus1.bin   = 24'd99;
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        drain1(60);
        repeat (40) @(negedge clk);
        check("start+auto single conversion", 32'(done1_cnt - snap), 32'd1);

        check("dut0 queue empty", 32'(q0.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
